// File: rtl/laser_draw_arbiter_pkg.sv
// Shared types and widths for the laser draw arbiter and its VGA write-port selector.
package laser_draw_arbiter_pkg;

  localparam int unsigned COORD_W  = 15;
  localparam int unsigned COLOUR_W = 9;
  localparam int unsigned CAR_W    = 4;

  // Coordinate word is {x[7:0], y[6:0]}
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned X_LSB = 7;
  localparam int unsigned Y_LSB = 0;

  // Wide enough to hold NUM_TOWERS itself (up to 8) as the end-of-scan marker
  localparam int unsigned PTR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    KICK,
    WAIT,
    FINISH
  } arb_state_e;

  // Per-laser signals selected by the current grant pointer
  typedef struct packed {
    logic                active;
    logic                done;
    logic                we;
    logic [COORD_W-1:0]  coords;
    logic [COLOUR_W-1:0] colour;
    logic [CAR_W-1:0]    destroyed;
  } laser_sel_t;

endpackage

// File: rtl/laser_draw_arbiter_vga_mux.sv
// Indexed combinational selector: picks one laser's slice out of the packed per-laser buses.
// An out-of-range select yields all zeros.
module laser_vga_mux
  import laser_draw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TOWERS = 4
) (
  input  logic [PTR_W-1:0]               sel,
  input  logic [NUM_TOWERS-1:0]          tower_active,
  input  logic [NUM_TOWERS-1:0]          laser_done,
  input  logic [NUM_TOWERS-1:0]          laser_we,
  input  logic [COORD_W*NUM_TOWERS-1:0]  laser_coords,
  input  logic [COLOUR_W*NUM_TOWERS-1:0] laser_colour,
  input  logic [CAR_W*NUM_TOWERS-1:0]    laser_destroyed,
  output laser_sel_t                     sel_c
);

  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < NUM_TOWERS; i++) begin
      if (sel == PTR_W'(i)) begin
        sel_c.active    = tower_active[i];
        sel_c.done      = laser_done[i];
        sel_c.we        = laser_we[i];
        sel_c.coords    = {laser_coords[COORD_W*i + X_LSB +: X_W],
                           laser_coords[COORD_W*i + Y_LSB +: Y_W]};
        sel_c.colour    = laser_colour[COLOUR_W*i +: COLOUR_W];
        sel_c.destroyed = laser_destroyed[CAR_W*i +: CAR_W];
      end
    end
  end

endmodule

// File: rtl/laser_draw_arbiter.sv
// Grants each active tower laser in turn, owns the single VGA write port and merges kill flags.
// Optional per-grant watchdog enabled with `define ARB_TIMEOUT_EN.
module laser_draw_arbiter
  import laser_draw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_TOWERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_TOWERS-1:0]          tower_active,
  input  logic [NUM_TOWERS-1:0]          laser_done,
  input  logic [NUM_TOWERS-1:0]          laser_we,
  input  logic [COORD_W*NUM_TOWERS-1:0]  laser_coords,
  input  logic [COLOUR_W*NUM_TOWERS-1:0] laser_colour,
  input  logic [CAR_W*NUM_TOWERS-1:0]    laser_destroyed,
  output logic [NUM_TOWERS-1:0]          enable_draw,
  output logic                           vga_WriteEn,
  output logic [COORD_W-1:0]             vga_coords,
  output logic [COLOUR_W-1:0]            vga_colour,
  output logic [CAR_W-1:0]               destroyed_cars,
  output logic                           cycle_done,
  output logic                           busy,
  output logic                           timeout_flag
);

  if (NUM_TOWERS < 1 || NUM_TOWERS > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("laser_draw_arbiter: unsupported NUM_TOWERS or TIMEOUT_CYCLES");
  end

  arb_state_e       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CAR_W-1:0] acc, acc_nxt;
  laser_sel_t       cur_c;
  logic             tmo_c;

  laser_vga_mux #(
    .NUM_TOWERS (NUM_TOWERS)
  ) u_mux (
    .sel             (ptr),
    .tower_active    (tower_active),
    .laser_done      (laser_done),
    .laser_we        (laser_we),
    .laser_coords    (laser_coords),
    .laser_colour    (laser_colour),
    .laser_destroyed (laser_destroyed),
    .sel_c           (cur_c)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;

  logic [TMO_W-1:0] tmo_cnt;

  // Counts cycles spent waiting on the current grant
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == KICK) begin
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_c && !cur_c.done) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign tmo_c = (state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_c        = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Next-state logic; a real done takes priority over a coincident timeout
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    acc_nxt   = acc;
    unique case (state)
      IDLE: begin
        ptr_nxt = '0;
        acc_nxt = '0;
        if (start) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (ptr >= PTR_W'(NUM_TOWERS)) begin
          state_nxt = FINISH;
        end else if (cur_c.active) begin
          state_nxt = KICK;
        end else begin
          ptr_nxt = ptr + PTR_W'(1);
        end
      end
      KICK: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cur_c.done) begin
          acc_nxt   = acc | cur_c.destroyed;
          ptr_nxt   = ptr + PTR_W'(1);
          state_nxt = SCAN;
        end else if (tmo_c) begin
          ptr_nxt   = ptr + PTR_W'(1);
          state_nxt = SCAN;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State plus registered strobes, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      acc            <= '0;
      enable_draw    <= '0;
      cycle_done     <= 1'b0;
      busy           <= 1'b0;
      destroyed_cars <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      acc         <= acc_nxt;
      enable_draw <= (state_nxt == KICK) ? (NUM_TOWERS'(1) << ptr_nxt) : '0;
      cycle_done  <= (state_nxt == FINISH);
      busy        <= (state_nxt != IDLE);
      if (state == FINISH) begin
        destroyed_cars <= acc;
      end
    end
  end

  // Zero-latency write-port mux, open only while a grant is outstanding
  always_comb begin
    vga_WriteEn = 1'b0;
    vga_coords  = '0;
    vga_colour  = '0;
    if (state == WAIT) begin
      vga_WriteEn = cur_c.we;
      vga_coords  = cur_c.coords;
      vga_colour  = cur_c.colour;
    end
  end

endmodule
